// File: rtl/hazard_stall_ctrl_if.sv
// Pipeline-side hazard information and stall/flush controls for hazard_stall_ctrl.
// master = datapath (drives hazard info, receives controls); slave = controller.
interface hazard_stall_ctrl_if;
  logic [4:0] IFID_RS1addr_i;
  logic [4:0] IFID_RS2addr_i;
  logic       IFID_RS1use_i;
  logic       IFID_RS2use_i;
  logic       IDEX_MemRead_i;
  logic [4:0] IDEX_RDaddr_i;
  logic       Branch_taken_i;
  // dmem_req_i/dmem_ack_i: a MEM access completes in the cycle both are 1;
  // req without ack freezes the pipeline until ack arrives.
  logic       dmem_req_i;
  logic       dmem_ack_i;
  logic       PCWrite_o;
  logic       IFID_Stall_o;
  logic       IFID_Flush_o;
  logic       IDEX_Stall_o;
  logic       IDEX_Flush_o;
  logic       EXMEM_Stall_o;
  logic       MEMWB_Flush_o;

  modport master (
    output IFID_RS1addr_i, IFID_RS2addr_i, IFID_RS1use_i, IFID_RS2use_i,
           IDEX_MemRead_i, IDEX_RDaddr_i, Branch_taken_i, dmem_req_i, dmem_ack_i,
    input  PCWrite_o, IFID_Stall_o, IFID_Flush_o, IDEX_Stall_o, IDEX_Flush_o,
           EXMEM_Stall_o, MEMWB_Flush_o
  );

  modport slave (
    input  IFID_RS1addr_i, IFID_RS2addr_i, IFID_RS1use_i, IFID_RS2use_i,
           IDEX_MemRead_i, IDEX_RDaddr_i, Branch_taken_i, dmem_req_i, dmem_ack_i,
    output PCWrite_o, IFID_Stall_o, IFID_Flush_o, IDEX_Stall_o, IDEX_Flush_o,
           EXMEM_Stall_o, MEMWB_Flush_o
  );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use, taken branch, dmem wait/timeout.
// Optional HAZARD_PERF_CNT_EN adds saturating stall/flush cycle counters.
module hazard_stall_ctrl #(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 8
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                start_i,
  hazard_stall_ctrl_if.slave  hz,
  output logic                err_o,
  output logic [1:0]          state_o
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]         stall_cnt_o,
  output logic [31:0]         flush_cnt_o
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RUN      = 2'd1,
    ST_MEM_WAIT = 2'd2,
    ST_ERROR    = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             err_q, err_d;

  logic load_use, mem_miss;
  logic pc_write, ifid_stall, ifid_flush, idex_stall, idex_flush, exmem_stall, memwb_flush;

  always_comb begin
    load_use = hz.IDEX_MemRead_i && (hz.IDEX_RDaddr_i != 5'd0) &&
               ((hz.IFID_RS1use_i && (hz.IFID_RS1addr_i == hz.IDEX_RDaddr_i)) ||
                (hz.IFID_RS2use_i && (hz.IFID_RS2addr_i == hz.IDEX_RDaddr_i)));
    mem_miss = hz.dmem_req_i && !hz.dmem_ack_i;
  end

  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    err_d       = err_q;
    pc_write    = 1'b0;
    ifid_stall  = 1'b0;
    ifid_flush  = 1'b0;
    idex_stall  = 1'b0;
    idex_flush  = 1'b0;
    exmem_stall = 1'b0;
    memwb_flush = 1'b0;
    case (state_q)
      ST_IDLE: begin
        ifid_stall = 1'b1;
        idex_flush = 1'b1;
        if (start_i) state_d = ST_RUN;
      end
      ST_RUN, ST_MEM_WAIT: begin
        if ((state_q == ST_RUN && mem_miss) || (state_q == ST_MEM_WAIT && !hz.dmem_ack_i)) begin
          ifid_stall  = 1'b1;
          idex_stall  = 1'b1;
          exmem_stall = 1'b1;
          memwb_flush = 1'b1;
          if (state_q == ST_RUN) begin
            state_d    = ST_MEM_WAIT;
            wait_cnt_d = CNT_W'(1);
          end else if (wait_cnt_q == CNT_W'(MEM_TIMEOUT)) begin
            state_d = ST_ERROR;
            err_d   = 1'b1;
          end else begin
            wait_cnt_d = wait_cnt_q + CNT_W'(1);
          end
        end else begin
          // Load-use outranks the branch: the branch operand is not ready yet.
          pc_write = 1'b1;
          if (load_use) begin
            pc_write   = 1'b0;
            ifid_stall = 1'b1;
            idex_flush = 1'b1;
          end else if (hz.Branch_taken_i) begin
            ifid_flush = 1'b1;
          end
          if (state_q == ST_MEM_WAIT) begin
            state_d    = ST_RUN;
            wait_cnt_d = '0;
          end
        end
      end
      default: begin
        ifid_stall  = 1'b1;
        idex_stall  = 1'b1;
        exmem_stall = 1'b1;
        memwb_flush = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= ST_IDLE;
      wait_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      err_q      <= err_d;
    end
  end

  assign hz.PCWrite_o     = pc_write;
  assign hz.IFID_Stall_o  = ifid_stall;
  assign hz.IFID_Flush_o  = ifid_flush;
  assign hz.IDEX_Stall_o  = idex_stall;
  assign hz.IDEX_Flush_o  = idex_flush;
  assign hz.EXMEM_Stall_o = exmem_stall;
  assign hz.MEMWB_Flush_o = memwb_flush;
  assign err_o            = err_q;
  assign state_o          = state_q;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if ((state_q == ST_RUN || state_q == ST_MEM_WAIT) && !pc_write && stall_cnt_q != 32'hFFFF_FFFF)
      stall_cnt_d = stall_cnt_q + 32'd1;
    if (state_q == ST_RUN && (ifid_flush || idex_flush) && flush_cnt_q != 32'hFFFF_FFFF)
      flush_cnt_d = flush_cnt_q + 32'd1;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Self-checking bench for hazard_stall_ctrl (MEM_TIMEOUT=4); perf counters checked when
// HAZARD_PERF_CNT_EN is defined.
module tb_hazard_stall_ctrl;
  logic       clk_i = 1'b0;
  logic       rst_i = 1'b0;
  logic       start_i = 1'b0;
  logic       err_o;
  logic [1:0] state_o;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt_o, flush_cnt_o;
`endif

  hazard_stall_ctrl_if hif();

  hazard_stall_ctrl #(.MEM_TIMEOUT(4), .CNT_W(8)) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .start_i (start_i),
    .hz      (hif),
    .err_o   (err_o),
    .state_o (state_o)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .stall_cnt_o (stall_cnt_o),
    .flush_cnt_o (flush_cnt_o)
`endif
  );

  // clock/reset block
  always #5 clk_i = ~clk_i;

  // control vector order: {PCWrite, IFID_Stall, IFID_Flush, IDEX_Stall, IDEX_Flush, EXMEM_Stall, MEMWB_Flush}
  localparam logic [6:0] O_IDLE = 7'b0100100;
  localparam logic [6:0] O_RUN  = 7'b1000000;
  localparam logic [6:0] O_FRZ  = 7'b0101011;
  localparam logic [6:0] O_LU   = 7'b0100100;
  localparam logic [6:0] O_BR   = 7'b1010000;

  logic [9:0] exp_q[$];
  int checks = 0;
  int failures = 0;

  function automatic logic [9:0] ev(input logic [1:0] st, input logic er, input logic [6:0] c);
    return {st, er, c};
  endfunction

  function automatic logic [9:0] obs();
    return {state_o, err_o, hif.PCWrite_o, hif.IFID_Stall_o, hif.IFID_Flush_o, hif.IDEX_Stall_o,
            hif.IDEX_Flush_o, hif.EXMEM_Stall_o, hif.MEMWB_Flush_o};
  endfunction

  // driver tasks
  task automatic drive(input logic mr, input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic u1, input logic u2,
                       input logic br, input logic req, input logic ack);
    hif.IDEX_MemRead_i = mr;
    hif.IDEX_RDaddr_i  = rd;
    hif.IFID_RS1addr_i = rs1;
    hif.IFID_RS2addr_i = rs2;
    hif.IFID_RS1use_i  = u1;
    hif.IFID_RS2use_i  = u2;
    hif.Branch_taken_i = br;
    hif.dmem_req_i     = req;
    hif.dmem_ack_i     = ack;
  endtask

  // s = {MemRead, Branch_taken, dmem_req, dmem_ack}; load targets x5, ID reads x5 via rs2
  task automatic apply(input logic [3:0] s);
    drive(s[3], 5'd5, 5'd0, 5'd5, 1'b0, 1'b1, s[2], s[1], s[0]);
  endtask

  task automatic test_reset();
    logic [9:0] got, e;
    apply(4'b0000);
    #2;
    exp_q.push_back(ev(2'd0, 1'b0, O_IDLE));
    got = obs(); e = exp_q.pop_front(); checks++;
    if (got !== e) begin failures++; $display("FAIL reset_state got=%b exp=%b", got, e); end
    @(negedge clk_i); rst_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) @(negedge clk_i);
      start_i = (i == 5);
      exp_q.push_back(ev(2'd0, 1'b0, O_IDLE));
      #2; got = obs(); e = exp_q.pop_front(); checks++;
      if (got !== e) begin failures++; $display("FAIL idle_hold[%0d] got=%b exp=%b", i, got, e); end
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk_i); start_i = (i == 0);
      exp_q.push_back(ev(2'd1, 1'b0, O_RUN));
      #2; got = obs(); e = exp_q.pop_front(); checks++;
      if (got !== e) begin failures++; $display("FAIL start_run[%0d] got=%b exp=%b", i, got, e); end
    end
  endtask

  task automatic test_load_use();
    logic [9:0] got, e;
    logic [3:0] st [6] = '{4'b1000, 4'b0000, 4'b1100, 4'b0100, 4'b0000, 4'b1000};
    logic [6:0] ex [6] = '{O_LU, O_RUN, O_LU, O_BR, O_RUN, O_LU};
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_i); apply(st[i]);
      exp_q.push_back(ev(2'd1, 1'b0, ex[i]));
      #2; got = obs(); e = exp_q.pop_front(); checks++;
      if (got !== e) begin failures++; $display("FAIL load_use_row[%0d] got=%b exp=%b", i, got, e); end
    end
    // rd = x0 never stalls, rs1 path matches, unused operand ignored
    @(negedge clk_i); drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    exp_q.push_back(ev(2'd1, 1'b0, O_RUN));
    #2; got = obs(); e = exp_q.pop_front(); checks++;
    if (got !== e) begin failures++; $display("FAIL rd_x0 got=%b exp=%b", got, e); end
    @(negedge clk_i); drive(1'b1, 5'd9, 5'd9, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    exp_q.push_back(ev(2'd1, 1'b0, O_LU));
    #2; got = obs(); e = exp_q.pop_front(); checks++;
    if (got !== e) begin failures++; $display("FAIL rs1_match got=%b exp=%b", got, e); end
    @(negedge clk_i); drive(1'b1, 5'd9, 5'd9, 5'd9, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    exp_q.push_back(ev(2'd1, 1'b0, O_BR));
    #2; got = obs(); e = exp_q.pop_front(); checks++;
    if (got !== e) begin failures++; $display("FAIL unused_regs got=%b exp=%b", got, e); end
    for (int i = 0; i < 12; i++) begin
      logic mr, u1, u2, br, hzd;
      logic [4:0] rd, r1, r2;
      mr = 1'($urandom_range(0, 1)); u1 = 1'($urandom_range(0, 1));
      u2 = 1'($urandom_range(0, 1)); br = 1'($urandom_range(0, 1));
      rd = 5'($urandom_range(0, 3)); r1 = 5'($urandom_range(0, 3)); r2 = 5'($urandom_range(0, 3));
      hzd = mr && (rd != 5'd0) && ((u1 && r1 == rd) || (u2 && r2 == rd));
      @(negedge clk_i); drive(mr, rd, r1, r2, u1, u2, br, 1'b0, 1'b0);
      exp_q.push_back(ev(2'd1, 1'b0, hzd ? O_LU : (br ? O_BR : O_RUN)));
      #2; got = obs(); e = exp_q.pop_front(); checks++;
      if (got !== e) begin failures++; $display("FAIL load_use_rand[%0d] got=%b exp=%b", i, got, e); end
    end
  endtask

  task automatic test_mem_wait();
    logic [9:0] got, e;
    logic [3:0] st [17] = '{4'b0010, 4'b0010, 4'b0010, 4'b0011, 4'b0000, 4'b0011, 4'b0111,
                            4'b0010, 4'b1011, 4'b0000, 4'b1110, 4'b0001, 4'b0000,
                            4'b0010, 4'b0000, 4'b0001, 4'b0000};
    logic [9:0] ex [17] = '{ev(2'd1, 1'b0, O_FRZ), ev(2'd2, 1'b0, O_FRZ), ev(2'd2, 1'b0, O_FRZ),
                            ev(2'd2, 1'b0, O_RUN), ev(2'd1, 1'b0, O_RUN), ev(2'd1, 1'b0, O_RUN),
                            ev(2'd1, 1'b0, O_BR),  ev(2'd1, 1'b0, O_FRZ), ev(2'd2, 1'b0, O_LU),
                            ev(2'd1, 1'b0, O_RUN), ev(2'd1, 1'b0, O_FRZ), ev(2'd2, 1'b0, O_RUN),
                            ev(2'd1, 1'b0, O_RUN), ev(2'd1, 1'b0, O_FRZ), ev(2'd2, 1'b0, O_FRZ),
                            ev(2'd2, 1'b0, O_RUN), ev(2'd1, 1'b0, O_RUN)};
    for (int i = 0; i < 17; i++) begin
      @(negedge clk_i); apply(st[i]);
      exp_q.push_back(ex[i]);
      #2; got = obs(); e = exp_q.pop_front(); checks++;
      if (got !== e) begin failures++; $display("FAIL mem_wait_row[%0d] got=%b exp=%b", i, got, e); end
    end
  endtask

  task automatic test_ack_at_timeout();
    logic [9:0] got, e;
    logic [3:0] st [6] = '{4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0011, 4'b0000};
    logic [9:0] ex [6] = '{ev(2'd1, 1'b0, O_FRZ), ev(2'd2, 1'b0, O_FRZ), ev(2'd2, 1'b0, O_FRZ),
                           ev(2'd2, 1'b0, O_FRZ), ev(2'd2, 1'b0, O_RUN), ev(2'd1, 1'b0, O_RUN)};
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_i); apply(st[i]);
      exp_q.push_back(ex[i]);
      #2; got = obs(); e = exp_q.pop_front(); checks++;
      if (got !== e) begin failures++; $display("FAIL ack_at_timeout[%0d] got=%b exp=%b", i, got, e); end
    end
  endtask

  task automatic test_reset_mid_wait();
    logic [9:0] got, e;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk_i); apply(4'b0010);
      exp_q.push_back(ev(i == 0 ? 2'd1 : 2'd2, 1'b0, O_FRZ));
      #2; got = obs(); e = exp_q.pop_front(); checks++;
      if (got !== e) begin failures++; $display("FAIL pre_reset[%0d] got=%b exp=%b", i, got, e); end
    end
    @(negedge clk_i); rst_i = 1'b0;
    exp_q.push_back(ev(2'd0, 1'b0, O_IDLE));
    #2; got = obs(); e = exp_q.pop_front(); checks++;
    if (got !== e) begin failures++; $display("FAIL reset_mid_wait got=%b exp=%b", got, e); end
    @(negedge clk_i); rst_i = 1'b1; apply(4'b0000); start_i = 1'b1;
    @(negedge clk_i); start_i = 1'b0;
    exp_q.push_back(ev(2'd1, 1'b0, O_RUN));
    #2; got = obs(); e = exp_q.pop_front(); checks++;
    if (got !== e) begin failures++; $display("FAIL restart got=%b exp=%b", got, e); end
  endtask

  task automatic test_timeout();
    logic [9:0] got, e;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk_i);
      apply(i < 7 ? 4'b0010 : (i == 7 ? 4'b0011 : 4'b0000));
      start_i = (i == 8);
      if (i == 0) exp_q.push_back(ev(2'd1, 1'b0, O_FRZ));
      else if (i < 5) exp_q.push_back(ev(2'd2, 1'b0, O_FRZ));
      else exp_q.push_back(ev(2'd3, 1'b1, O_FRZ));
      #2; got = obs(); e = exp_q.pop_front(); checks++;
      if (got !== e) begin failures++; $display("FAIL timeout[%0d] got=%b exp=%b", i, got, e); end
    end
    @(negedge clk_i); start_i = 1'b0; rst_i = 1'b0;
    exp_q.push_back(ev(2'd0, 1'b0, O_IDLE));
    #2; got = obs(); e = exp_q.pop_front(); checks++;
    if (got !== e) begin failures++; $display("FAIL error_reset got=%b exp=%b", got, e); end
    @(negedge clk_i); rst_i = 1'b1;
    @(negedge clk_i);
    exp_q.push_back(ev(2'd0, 1'b0, O_IDLE));
    #2; got = obs(); e = exp_q.pop_front(); checks++;
    if (got !== e) begin failures++; $display("FAIL post_error_idle got=%b exp=%b", got, e); end
  endtask

`ifdef HAZARD_PERF_CNT_EN
  task automatic test_perf_cnt();
    logic [9:0] got, e;
    logic [3:0] st [7] = '{4'b0010, 4'b0010, 4'b0010, 4'b0011, 4'b1000, 4'b0100, 4'b0000};
    logic [9:0] ex [7] = '{ev(2'd1, 1'b0, O_FRZ), ev(2'd2, 1'b0, O_FRZ), ev(2'd2, 1'b0, O_FRZ),
                           ev(2'd2, 1'b0, O_RUN), ev(2'd1, 1'b0, O_LU), ev(2'd1, 1'b0, O_BR),
                           ev(2'd1, 1'b0, O_RUN)};
    @(negedge clk_i); rst_i = 1'b0; apply(4'b0000);
    #2; checks++;
    if (stall_cnt_o !== 32'd0 || flush_cnt_o !== 32'd0) begin
      failures++; $display("FAIL perf_reset got=%0d/%0d exp=0/0", stall_cnt_o, flush_cnt_o);
    end
    @(negedge clk_i); rst_i = 1'b1;
    @(negedge clk_i); start_i = 1'b1;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk_i); start_i = 1'b0; apply(st[i]);
      exp_q.push_back(ex[i]);
      #2; got = obs(); e = exp_q.pop_front(); checks++;
      if (got !== e) begin failures++; $display("FAIL perf_row[%0d] got=%b exp=%b", i, got, e); end
    end
    @(negedge clk_i); #2; checks++;
    if (stall_cnt_o !== 32'd4 || flush_cnt_o !== 32'd2) begin
      failures++; $display("FAIL perf_counts got=%0d/%0d exp=4/2", stall_cnt_o, flush_cnt_o);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_load_use();
    test_mem_wait();
    test_ack_at_timeout();
    test_reset_mid_wait();
    test_timeout();
`ifdef HAZARD_PERF_CNT_EN
    test_perf_cnt();
`endif
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_leftover got=%0d exp=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage RISC-V pipeline.
- Drives the write-enable, stall and flush controls of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers.
- Hazard sources: load-use data hazards, taken branches resolved in ID, and a multi-cycle data-memory handshake with timeout.
- Holds the whole pipeline idle from reset until start_i.

Parameters:
- MEM_TIMEOUT, 255: maximum MEM_WAIT cycles before entering ERROR; legal range 1..2^CNT_W-1.
- CNT_W, 8: width of the wait counter.

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  reset, asynchronous, active-low
- start_i  in  1  level; leave IDLE when 1
- IFID_RS1addr_i  in  5  rs1 of the instruction in ID
- IFID_RS2addr_i  in  5  rs2 of the instruction in ID
- IFID_RS1use_i  in  1  instruction in ID reads rs1
- IFID_RS2use_i  in  1  instruction in ID reads rs2
- IDEX_MemRead_i  in  1  instruction in EX is a load
- IDEX_RDaddr_i  in  5  rd of the instruction in EX
- Branch_taken_i  in  1  branch in ID resolved taken
- dmem_req_i  in  1  MEM stage access pending
- dmem_ack_i  in  1  data memory completes access this cycle
- PCWrite_o  out  1  PC update enable
- IFID_Stall_o  out  1  hold IF/ID
- IFID_Flush_o  out  1  zero IF/ID (NOP)
- IDEX_Stall_o  out  1  hold ID/EX
- IDEX_Flush_o  out  1  load bubble into ID/EX (control fields 0)
- EXMEM_Stall_o  out  1  hold EX/MEM
- MEMWB_Flush_o  out  1  load bubble into MEM/WB
- err_o  out  1  memory timeout, sticky
- state_o  out  2  IDLE=0, RUN=1, MEM_WAIT=2, ERROR=3

Behaviour:
- Registered elements: state, wait_cnt, err flag. Control outputs are Mealy: combinational from state and current inputs, same-cycle effect.
- Reset (rst_i=0, asynchronous): state=IDLE, wait_cnt=0, err_o=0.
- Output values while in reset / IDLE: PCWrite_o=0, IFID_Stall_o=1, IDEX_Flush_o=1, all other control outputs 0, state_o=0.
- IDLE:
  - Outputs as above.
  - start_i=1 -> RUN at next edge.
- RUN defaults: PCWrite_o=1, all stall/flush outputs 0.
- RUN conditions, highest priority first:
  1. Memory miss (dmem_req_i=1, dmem_ack_i=0):
     - PCWrite_o=0; IFID_Stall_o, IDEX_Stall_o, EXMEM_Stall_o=1; MEMWB_Flush_o=1; IDEX_Flush_o=0; IFID_Flush_o=0.
     - Next state MEM_WAIT; wait_cnt<=1.
  2. Load-use hazard:
     - Condition: IDEX_MemRead_i=1, IDEX_RDaddr_i!=0, and (IFID_RS1use_i and RS1 match) or (IFID_RS2use_i and RS2 match).
     - Outputs: PCWrite_o=0, IFID_Stall_o=1, IDEX_Flush_o=1, IFID_Flush_o=0. The branch flush is suppressed because the branch operand is not ready.
     - Exactly one bubble per hazard.
  3. Branch_taken_i=1: IFID_Flush_o=1, PCWrite_o=1.
- dmem_req_i and dmem_ack_i both 1 in RUN: single-cycle hit, no stall; rules 2-3 apply.
- MEM_WAIT:
  - dmem_ack_i=0: same frozen outputs as rule 1; wait_cnt increments.
  - When wait_cnt reaches MEM_TIMEOUT with ack still 0: next state ERROR, err_o<=1.
  - dmem_ack_i=1: freeze released this cycle (RUN default outputs; rules 2-3 evaluated); next state RUN; wait_cnt<=0.
  - Ack arriving in the same cycle wait_cnt==MEM_TIMEOUT: ack wins, go to RUN.
- ERROR:
  - PCWrite_o=0; all Stall outputs=1; MEMWB_Flush_o=1; err_o=1.
  - Exits only via reset; start_i is ignored.
- start_i is ignored outside IDLE.
- Reset asserted mid-MEM_WAIT: immediate return to IDLE, wait_cnt cleared.
- rd=x0 never raises a hazard.

Optional Feature:
- Macro: HAZARD_PERF_CNT_EN.
- Defined: adds outputs stall_cnt_o[31:0] and flush_cnt_o[31:0].
  - stall_cnt_o increments on every cycle with PCWrite_o=0 in RUN or MEM_WAIT.
  - flush_cnt_o increments on every cycle with IFID_Flush_o=1 or IDEX_Flush_o=1 in RUN.
  - Both saturate at 0xFFFFFFFF and reset to 0.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset, then start_i=0 for 5 cycles -> state_o=0, PCWrite_o=0, IFID_Stall_o=1 throughout. Then start_i=1 -> state_o=1 next cycle, PCWrite_o=1.
- RUN with IDEX_MemRead_i=1, IDEX_RDaddr_i=5, IFID_RS2addr_i=5, IFID_RS2use_i=1 -> one cycle of PCWrite_o=0, IFID_Stall_o=1, IDEX_Flush_o=1. Repeat with RDaddr=0 -> no stall.
- Load-use hazard plus Branch_taken_i=1 in the same cycle -> IFID_Flush_o=0, IDEX_Flush_o=1. Next cycle with MemRead=0 and branch=1 -> IFID_Flush_o=1.
- dmem_req_i=1, dmem_ack_i=0 for 3 cycles, then ack=1 -> state_o=2 for 3 cycles with EXMEM_Stall_o=1 and MEMWB_Flush_o=1. Ack cycle: all stalls 0; state_o=1 next.
- MEM_TIMEOUT=4, ack held 0 -> state_o=3 and err_o=1 after the 4th wait cycle. Later ack=1 or start_i=1 has no effect. Reset pulse -> state_o=0, err_o=0.
- With HAZARD_PERF_CNT_EN: 3-cycle miss plus 1 load-use plus 1 taken branch -> stall_cnt_o=4, flush_cnt_o=2.
